// File: rtl/tag_lookup_ctrl.sv
// rtl/tag_lookup_ctrl.sv - two-way tag lookup controller with LRU allocation
//
// Purpose: accepts one lookup request at a time, reads both ways of an
// external synchronous-read tag RAM, reports hit/way, and optionally
// allocates a victim way on a miss. Optional flush is built in when the
// macro TAG_FLUSH_EN is defined.
//
// Ports:
//   clock, reset_n            clock, asynchronous active-low reset
//   req_valid/req_ready       request handshake
//   req_index/req_tag         set index and tag to look up
//   req_alloc                 allocate a way on miss
//   resp_valid                one-cycle response strobe
//   resp_hit/resp_way         hit flag and hit/allocated way (held until next response)
//   t0_*/t1_*                 way-0/way-1 tag RAM address, write data, write enable, read data
//   flush_start/flush_busy    (TAG_FLUSH_EN only) start and status of a full-array flush
module tag_lookup_ctrl #(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 16,
    parameter int TWIDTH = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [AWIDTH-1:0] req_index,
    input  logic [TWIDTH-1:0] req_tag,
    input  logic              req_alloc,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic              resp_way,
    output logic [AWIDTH-1:0] t0_addr,
    output logic [AWIDTH-1:0] t1_addr,
    output logic [DWIDTH-1:0] t0_din,
    output logic [DWIDTH-1:0] t1_din,
    output logic              t0_we,
    output logic              t1_we,
    input  logic [DWIDTH-1:0] t0_dout,
    input  logic [DWIDTH-1:0] t1_dout
`ifdef TAG_FLUSH_EN
    ,
    input  logic              flush_start,
    output logic              flush_busy
`endif
);

    localparam int DEPTH = 1 << AWIDTH;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_RESP   = 2'd2
`ifdef TAG_FLUSH_EN
        ,
        S_FLUSH  = 2'd3
`endif
    } state_t;

    state_t            state;
    logic [AWIDTH-1:0] idx_q;
    logic [TWIDTH-1:0] tag_q;
    logic              alloc_q;
    logic [DEPTH-1:0]  lru;
`ifdef TAG_FLUSH_EN
    logic [AWIDTH-1:0] fcnt;
`endif

    logic              hit0;
    logic              hit1;
    logic              hit;
    logic              hit_way;
    logic              victim;
    logic              do_alloc;
    logic [DWIDTH-1:0] new_entry;
    logic              unused_dout;

    // Middle entry bits are always written as zero and never inspected.
    assign unused_dout = &{1'b0, t0_dout, t1_dout};

    assign hit0    = t0_dout[DWIDTH-1] && (t0_dout[TWIDTH-1:0] == tag_q);
    assign hit1    = t1_dout[DWIDTH-1] && (t1_dout[TWIDTH-1:0] == tag_q);
    assign hit     = hit0 || hit1;
    assign hit_way = !hit0;                 // way 0 wins when both match

    // Fill invalid ways first (way 0 before way 1), then evict the LRU way.
    always_comb begin
        victim = lru[idx_q];
        if (!t0_dout[DWIDTH-1]) begin
            victim = 1'b0;
        end else if (!t1_dout[DWIDTH-1]) begin
            victim = 1'b1;
        end
    end

    assign do_alloc = (state == S_LOOKUP) && !hit && alloc_q;

    always_comb begin
        new_entry             = '0;
        new_entry[DWIDTH-1]   = 1'b1;
        new_entry[TWIDTH-1:0] = tag_q;
    end

    assign req_ready = (state == S_IDLE);
`ifdef TAG_FLUSH_EN
    assign flush_busy = (state == S_FLUSH);
`endif

    // RAM port steering. Write enables decode straight from the state
    // register, so the asynchronous reset drops them without a clock.
    always_comb begin
        t0_addr = idx_q;
        t1_addr = idx_q;
        t0_din  = new_entry;
        t1_din  = new_entry;
        t0_we   = 1'b0;
        t1_we   = 1'b0;
        case (state)
            S_IDLE: begin
                t0_addr = req_index;
                t1_addr = req_index;
            end
            S_LOOKUP: begin
                t0_we = do_alloc && !victim;
                t1_we = do_alloc &&  victim;
            end
`ifdef TAG_FLUSH_EN
            S_FLUSH: begin
                t0_addr = fcnt;
                t1_addr = fcnt;
                t0_din  = '0;
                t1_din  = '0;
                t0_we   = 1'b1;
                t1_we   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            idx_q      <= '0;
            tag_q      <= '0;
            alloc_q    <= 1'b0;
            lru        <= '0;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_way   <= 1'b0;
`ifdef TAG_FLUSH_EN
            fcnt       <= '0;
`endif
        end else begin
            resp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
`ifdef TAG_FLUSH_EN
                    if (flush_start) begin
                        fcnt  <= '0;
                        state <= S_FLUSH;
                    end else
`endif
                    if (req_valid) begin
                        idx_q   <= req_index;
                        tag_q   <= req_tag;
                        alloc_q <= req_alloc;
                        state   <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    resp_valid <= 1'b1;
                    resp_hit   <= hit;
                    if (hit) begin
                        resp_way     <= hit_way;
                        lru[idx_q]   <= !hit_way;
                    end else if (alloc_q) begin
                        resp_way     <= victim;
                        lru[idx_q]   <= !victim;
                    end else begin
                        resp_way     <= 1'b0;
                    end
                    state <= S_RESP;
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
`ifdef TAG_FLUSH_EN
                S_FLUSH: begin
                    if (fcnt == AWIDTH'(DEPTH - 1)) begin
                        lru   <= '0;
                        state <= S_IDLE;
                    end
                    fcnt <= fcnt + AWIDTH'(1);
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// tb/tb_tag_lookup_ctrl.sv - directed self-checking bench for tag_lookup_ctrl
module tb_tag_lookup_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_index;
    logic [7:0]  req_tag;
    logic        req_alloc;
    logic        resp_valid;
    logic        resp_hit;
    logic        resp_way;
    logic [2:0]  t0_addr;
    logic [2:0]  t1_addr;
    logic [15:0] t0_din;
    logic [15:0] t1_din;
    logic        t0_we;
    logic        t1_we;
    logic [15:0] t0_dout;
    logic [15:0] t1_dout;
`ifdef TAG_FLUSH_EN
    logic        flush_start;
    logic        flush_busy;
`endif

    logic [15:0] mem0 [8];
    logic [15:0] mem1 [8];

    int n_cmp = 0;
    int n_err = 0;

    logic r_hit, r_way, r_we0, r_we1;
    int   r_lat;

    always #5 clock = ~clock;

    tag_lookup_ctrl #(.AWIDTH(3), .DWIDTH(16), .TWIDTH(8)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_index  (req_index),
        .req_tag    (req_tag),
        .req_alloc  (req_alloc),
        .resp_valid (resp_valid),
        .resp_hit   (resp_hit),
        .resp_way   (resp_way),
        .t0_addr    (t0_addr),
        .t1_addr    (t1_addr),
        .t0_din     (t0_din),
        .t1_din     (t1_din),
        .t0_we      (t0_we),
        .t1_we      (t1_we),
        .t0_dout    (t0_dout),
        .t1_dout    (t1_dout)
`ifdef TAG_FLUSH_EN
        ,
        .flush_start(flush_start),
        .flush_busy (flush_busy)
`endif
    );

    // Behavioural synchronous-read RAMs, read-before-write.
    always @(posedge clock) begin
        if (t0_we) mem0[t0_addr] <= t0_din;
        if (t1_we) mem1[t1_addr] <= t1_din;
        t0_dout <= mem0[t0_addr];
        t1_dout <= mem1[t1_addr];
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Issue one request from IDLE and collect its response.
    task automatic do_req(input logic [2:0] i, input logic [7:0] t, input logic a);
        bit got;
        @(negedge clock);
        req_valid = 1'b1;
        req_index = i;
        req_tag   = t;
        req_alloc = a;
        @(posedge clock);
        #1 req_valid = 1'b0;
        r_we0 = 1'b0;
        r_we1 = 1'b0;
        r_lat = 0;
        r_hit = 1'bx;
        r_way = 1'bx;
        got   = 1'b0;
        for (int k = 1; k <= 8 && !got; k++) begin
            @(negedge clock);
            r_we0 = r_we0 | t0_we;
            r_we1 = r_we1 | t1_we;
            if (resp_valid) begin
                got   = 1'b1;
                r_lat = k;
                r_hit = resp_hit;
                r_way = resp_way;
            end
        end
    endtask

    initial begin
        int busy_cnt;
        int seen;
        for (int k = 0; k < 8; k++) begin
            mem0[k] = '0;
            mem1[k] = '0;
        end
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_index = '0;
        req_tag   = '0;
        req_alloc = 1'b0;
`ifdef TAG_FLUSH_EN
        flush_start = 1'b0;
`endif
        repeat (3) @(negedge clock);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_hit", resp_hit, 0);
        check("rst_we", {t0_we, t1_we}, 0);
        check("rst_lru", dut.lru, 0);
        check("rst_ready", req_ready, 1);
        reset_n = 1'b1;

        // Cold miss with allocation
        do_req(3'd2, 8'h5A, 1'b1);
        check("cold_lat", r_lat, 2);
        check("cold_hit", r_hit, 0);
        check("cold_way", r_way, 0);
        check("cold_we", {r_we0, r_we1}, 2'b10);
        check("cold_mem0", mem0[2], 16'h805A);
        check("cold_lru", dut.lru[2], 1);

        // Hit on way 0
        do_req(3'd2, 8'h5A, 1'b1);
        check("hit_lat", r_lat, 2);
        check("hit_hit", r_hit, 1);
        check("hit_way", r_way, 0);
        check("hit_we", {r_we0, r_we1}, 0);
        check("hit_lru", dut.lru[2], 1);

        // Fill way 1, then LRU eviction of way 0
        do_req(3'd2, 8'h33, 1'b1);
        check("fill_hit", r_hit, 0);
        check("fill_way", r_way, 1);
        check("fill_mem1", mem1[2], 16'h8033);
        check("fill_lru", dut.lru[2], 0);
        do_req(3'd2, 8'h77, 1'b1);
        check("evict_way", r_way, 0);
        check("evict_mem0", mem0[2], 16'h8077);
        check("evict_mem1", mem1[2], 16'h8033);
        check("evict_lru", dut.lru[2], 1);
        do_req(3'd2, 8'h5A, 1'b0);
        check("gone_hit", r_hit, 0);
        check("gone_way", r_way, 0);

        // Hit on way 1, and response fields held afterwards
        do_req(3'd2, 8'h33, 1'b0);
        check("hit1_hit", r_hit, 1);
        check("hit1_way", r_way, 1);
        check("hit1_lru", dut.lru[2], 0);
        repeat (3) @(negedge clock);
        check("hold_valid", resp_valid, 0);
        check("hold_hit", {resp_hit, resp_way}, 2'b11);

        // Miss without allocation
        do_req(3'd5, 8'h11, 1'b0);
        check("noalloc_hit", r_hit, 0);
        check("noalloc_way", r_way, 0);
        check("noalloc_we", {r_we0, r_we1}, 0);
        check("noalloc_mem", {mem0[5], mem1[5]}, 0);
        check("noalloc_lru", dut.lru, 8'h00);

        // Reset during the LOOKUP cycle of an allocating miss
        @(negedge clock);
        req_valid = 1'b1;
        req_index = 3'd5;
        req_tag   = 8'h22;
        req_alloc = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        check("abort_we_before", {t0_we, t1_we}, 2'b10);
        #1 reset_n = 1'b0;
        #1 check("abort_we_now", {t0_we, t1_we}, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            if (resp_valid) seen++;
        end
        check("abort_no_resp", seen, 0);
        check("abort_ready", req_ready, 1);
        check("abort_mem", {mem0[5], mem1[5]}, 0);

`ifdef TAG_FLUSH_EN
        // Flush wins over a simultaneous request, which is then served
        @(negedge clock);
        flush_start = 1'b1;
        req_valid   = 1'b1;
        req_index   = 3'd2;
        req_tag     = 8'h77;
        req_alloc   = 1'b0;
        @(posedge clock);
        #1 flush_start = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (flush_busy) busy_cnt++;
            else break;
        end
        check("flush_busy_cycles", busy_cnt, 8);
        @(posedge clock);
        #1 req_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 6 && seen == 0; k++) begin
            @(negedge clock);
            if (resp_valid) begin
                seen = 1;
                check("flush_req_hit", resp_hit, 0);
            end
        end
        check("flush_req_resp", seen, 1);
        seen = 0;
        for (int k = 0; k < 8; k++) if (mem0[k] != 0 || mem1[k] != 0) seen++;
        check("flush_mem_zero", seen, 0);
        check("flush_lru", dut.lru, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
